// File: rtl/instruction_encoder_if.sv
// Field-bundle input and encoded-word output of the instruction encoder.
// The bench drives through master; the encoder sits on slave.
interface instruction_encoder_if;
    logic       in_valid;
    logic       in_ready;
    logic       alu_instruction;
    logic [2:0] source_select;
    logic [2:0] destination_select;
    logic [2:0] effect;
    logic [6:0] immediate;
    logic       increment;
    logic [4:0] alu_code;
    logic       out_valid;
    logic       out_ready;
    logic [15:0] out_instruction;

    modport master (
        output in_valid, alu_instruction, source_select, destination_select,
               effect, immediate, increment, alu_code, out_ready,
        input  in_ready, out_valid, out_instruction
    );

    modport slave (
        input  in_valid, alu_instruction, source_select, destination_select,
               effect, immediate, increment, alu_code, out_ready,
        output in_ready, out_valid, out_instruction
    );
endinterface

// File: rtl/instruction_encoder.sv
// Packs copy/ALU field bundles into 16-bit instruction words through a 2-entry
// output FIFO; unencodable bundles are consumed, counted and flagged.
module instruction_encoder #(
    parameter int ERR_W = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    instruction_encoder_if.slave bus,
    output logic                 reject,
    output logic [ERR_W-1:0]     error_count,
    output logic [1:0]           fifo_level
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1; valid-side data must stay stable until that edge, and
    // in_ready depends only on registered occupancy, never on out_ready.

    logic [15:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        accept;
    logic        bad;
    logic        push;
    logic        pop;
    logic [15:0] word;

    assign bus.in_ready  = (fifo_level != 2'd2);
    assign bus.out_valid = (fifo_level != 2'd0);
    assign bus.out_instruction = bus.out_valid ? mem[rd_ptr] : 16'h0000;

    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = bus.out_valid && bus.out_ready;
    assign push   = accept && !bad;

    always_comb begin
        bad  = 1'b0;
        word = 16'h0000;
        if (bus.alu_instruction) begin
            bad  = (bus.alu_code == 5'h1F);
            word = {1'b1, bus.effect, bus.destination_select, bus.source_select,
                    bus.increment, bus.alu_code};
        end else begin
            // Immediate must fit in 6 signed bits; copies have no increment.
            bad  = (bus.immediate[6] != bus.immediate[5]) || bus.increment;
            word = {1'b0, bus.effect, bus.destination_select, bus.source_select,
                    bus.immediate[5:0]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem[0]     <= 16'h0000;
            mem[1]     <= 16'h0000;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_level <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 2'd1;
                2'b01:   fifo_level <= fifo_level - 2'd1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reject      <= 1'b0;
            error_count <= '0;
        end else begin
            reject <= accept && bad;
            if (accept && bad && (error_count != {ERR_W{1'b1}})) begin
                error_count <= error_count + {{(ERR_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: expected words are queued at issue
// time and a negedge monitor compares them as the encoder emits.
module tb_instruction_encoder;

  logic       clock;
  logic       reset_n;
  logic       reject;
  logic [7:0] error_count;
  logic [1:0] fifo_level;

  instruction_encoder_if bus ();

  instruction_encoder #(.ERR_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .reject      (reject),
    .error_count (error_count),
    .fifo_level  (fifo_level)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_err  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (reset_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got 0x%0h expected no word", bus.out_instruction);
      end else if (bus.out_ready) begin
        check("out_word", {16'h0, bus.out_instruction}, {16'h0, exp_q.pop_front()});
      end else begin
        check("hold_word", {16'h0, bus.out_instruction}, {16'h0, exp_q[0]});
      end
    end
  end

  task automatic set_bundle(input logic alu, input logic [2:0] eff, input logic [2:0] dst,
                            input logic [2:0] src, input logic [6:0] imm, input logic inc,
                            input logic [4:0] code);
    bus.alu_instruction    = alu;
    bus.effect             = eff;
    bus.destination_select = dst;
    bus.source_select      = src;
    bus.immediate          = imm;
    bus.increment          = inc;
    bus.alu_code           = code;
  endtask

  // driver: issue one bundle, wait for acceptance, check the reject side
  task automatic send(input logic alu, input logic [2:0] eff, input logic [2:0] dst,
                      input logic [2:0] src, input logic [6:0] imm, input logic inc,
                      input logic [4:0] code, input logic [15:0] exp_word, input logic bad);
    int waits;
    set_bundle(alu, eff, dst, src, imm, inc, code);
    bus.in_valid = 1'b1;
    if (!bad) exp_q.push_back(exp_word);
    waits = 0;
    forever begin
      @(negedge clock);
      if (bus.in_ready) break;
      waits++;
      if (waits > 50) begin
        n_checks++;
        $display("FAIL accept_timeout: got no in_ready expected accept within 50 cycles");
        bus.in_valid = 1'b0;
        return;
      end
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    check("reject_pulse", {31'h0, reject}, {31'h0, bad});
    if (bad) begin
      if (exp_err < 255) exp_err++;
      check("error_count", {24'h0, error_count}, exp_err);
      @(posedge clock);
      #1;
      check("reject_one_cycle", {31'h0, reject}, 32'h0);
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("drain_empty", exp_q.size(), 0);
    check("drain_level", {30'h0, fifo_level}, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_bundle(1'b0, 3'd0, 3'd0, 3'd0, 7'h00, 1'b0, 5'h00);
    #1;
    check("rst_level", {30'h0, fifo_level}, 0);
    check("rst_out_valid", {31'h0, bus.out_valid}, 0);
    check("rst_out_word", {16'h0, bus.out_instruction}, 0);
    check("rst_in_ready", {31'h0, bus.in_ready}, 1);
    check("rst_err", {24'h0, error_count}, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // copy encoding, visible one cycle after accept
    send(1'b0, 3'd7, 3'd2, 3'd1, 7'h05, 1'b0, 5'h00, 16'h7445, 1'b0);
    check("copy_visible", {31'h0, bus.out_valid}, 1);
    check("copy_word", {16'h0, bus.out_instruction}, 16'h7445);
    drain();

    // immediate range
    send(1'b0, 3'd0, 3'd0, 3'd0, 7'h40, 1'b0, 5'h00, 16'h0000, 1'b1);
    check("range_no_word", {31'h0, bus.out_valid}, 0);
    send(1'b0, 3'd0, 3'd0, 3'd0, 7'h60, 1'b0, 5'h00, 16'h0020, 1'b0);
    check("imm_min_word", {16'h0, bus.out_instruction}, 16'h0020);
    send(1'b0, 3'd0, 3'd3, 3'd4, 7'h1F, 1'b0, 5'h00, 16'h071F, 1'b0);
    send(1'b0, 3'd0, 3'd0, 3'd0, 7'h20, 1'b0, 5'h00, 16'h0000, 1'b1);
    drain();

    // ALU encoding, reserved code, copy with increment
    send(1'b1, 3'd1, 3'd5, 3'd3, 7'h00, 1'b1, 5'h0A, 16'h9AEA, 1'b0);
    send(1'b1, 3'd7, 3'd7, 3'd7, 7'h40, 1'b0, 5'h1E, 16'hFFDE, 1'b0);
    drain();
    send(1'b1, 3'd1, 3'd1, 3'd1, 7'h00, 1'b0, 5'h1F, 16'h0000, 1'b1);
    send(1'b0, 3'd1, 3'd1, 3'd1, 7'h00, 1'b1, 5'h00, 16'h0000, 1'b1);
    check("rejects_no_word", {31'h0, bus.out_valid}, 0);

    // out_ready ignored when empty
    repeat (2) @(posedge clock);
    #1;
    check("idle_level", {30'h0, fifo_level}, 0);

    // simultaneous push and pop at level 1
    bus.out_ready = 1'b0;
    send(1'b0, 3'd0, 3'd0, 3'd0, 7'h03, 1'b0, 5'h00, 16'h0003, 1'b0);
    bus.out_ready = 1'b1;
    send(1'b1, 3'd0, 3'd1, 3'd2, 7'h00, 1'b1, 5'h03, 16'h82A3, 1'b0);
    check("pushpop_level", {30'h0, fifo_level}, 1);
    check("pushpop_head", {16'h0, bus.out_instruction}, 16'h82A3);
    drain();

    // reject coinciding with pop only pops
    bus.out_ready = 1'b0;
    send(1'b0, 3'd0, 3'd0, 3'd0, 7'h04, 1'b0, 5'h00, 16'h0004, 1'b0);
    bus.out_ready = 1'b1;
    send(1'b1, 3'd0, 3'd0, 3'd0, 7'h00, 1'b0, 5'h1F, 16'h0000, 1'b1);
    check("rejpop_level", {30'h0, fifo_level}, 0);
    drain();

    // backpressure
    bus.out_ready = 1'b0;
    send(1'b0, 3'd1, 3'd1, 3'd1, 7'h01, 1'b0, 5'h00, 16'h1241, 1'b0);
    send(1'b1, 3'd2, 3'd0, 3'd0, 7'h00, 1'b0, 5'h01, 16'hA001, 1'b0);
    fork
      send(1'b0, 3'd3, 3'd2, 3'd5, 7'h7F, 1'b0, 5'h00, 16'h357F, 1'b0);
      begin
        repeat (3) begin
          @(negedge clock);
          check("bp_in_ready", {31'h0, bus.in_ready}, 0);
          check("bp_level", {30'h0, fifo_level}, 2);
        end
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // reset mid-operation
    bus.out_ready = 1'b0;
    send(1'b0, 3'd1, 3'd1, 3'd1, 7'h01, 1'b0, 5'h00, 16'h1241, 1'b0);
    send(1'b1, 3'd2, 3'd0, 3'd0, 7'h00, 1'b0, 5'h01, 16'hA001, 1'b0);
    set_bundle(1'b0, 3'd3, 3'd2, 3'd5, 7'h7F, 1'b0, 5'h00);
    bus.in_valid = 1'b1;
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    exp_err = 0;
    check("mid_rst_level", {30'h0, fifo_level}, 0);
    check("mid_rst_valid", {31'h0, bus.out_valid}, 0);
    check("mid_rst_word", {16'h0, bus.out_instruction}, 0);
    check("mid_rst_in_ready", {31'h0, bus.in_ready}, 1);
    check("mid_rst_reject", {31'h0, reject}, 0);
    check("mid_rst_err", {24'h0, error_count}, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    set_bundle(1'b0, 3'd5, 3'd5, 3'd5, 7'h00, 1'b0, 5'h00);
    bus.in_valid = 1'b1;
    exp_q.push_back(16'h5B40);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    check("post_rst_level", {30'h0, fifo_level}, 1);
    check("post_rst_word", {16'h0, bus.out_instruction}, 16'h5B40);
    drain();

    // counter saturation
    for (int i = 0; i < 300; i++) begin
      send(1'b1, 3'd0, 3'd0, 3'd0, 7'h00, 1'b0, 5'h1F, 16'h0000, 1'b1);
    end
    check("err_saturated", {24'h0, error_count}, 255);
    check("sat_no_word", {31'h0, bus.out_valid}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
